// File: rtl/bmp180_frame_collector.sv
// Assembles BMP180 read frames (ID, calibration, UT, UP) from I2C master bytes into word registers.
// Optional build macro BMP180_ID_CHECK_EN: ID frames are validated against CHIP_ID.
module bmp180_frame_collector #(
    parameter int         CALIB_BYTES = 22,
    parameter logic [7:0] CHIP_ID     = 8'h55
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [1:0]  frame_kind,
    input  logic [1:0]  oss,
    input  logic        received,
    input  logic [7:0]  datareceive,
    input  logic [3:0]  calib_sel,
    output logic [15:0] calib_word,
    output logic [7:0]  chip_id,
    output logic [15:0] ut,
    output logic [18:0] up,
    output logic        id_valid,
    output logic        calib_valid,
    output logic        ut_valid,
    output logic        up_valid,
    output logic        frame_done,
    output logic        busy,
    output logic        frame_error
);

    localparam int CALIB_WORDS = CALIB_BYTES / 2;
    localparam int CW          = $clog2(CALIB_BYTES + 1);

    localparam logic [1:0] KIND_ID    = 2'd0;
    localparam logic [1:0] KIND_CALIB = 2'd1;
    localparam logic [1:0] KIND_TEMP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t           state;
    logic             received_q;
    logic             rx_evt;
    logic [1:0]       kind_reg;
    logic [1:0]       oss_reg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    expected;
    logic [7:0]       stage [0:2];
    logic [15:0]      calib_mem [0:CALIB_WORDS-1];
    logic [CALIB_WORDS-1:0] word_bad;
    logic             calib_ok;

    function automatic logic [CW-1:0] frame_len(input logic [1:0] k);
        case (k)
            KIND_ID:    return CW'(1);
            KIND_CALIB: return CW'(CALIB_BYTES);
            KIND_TEMP:  return CW'(2);
            default:    return CW'(3);
        endcase
    endfunction

    assign rx_evt = received & ~received_q;
    assign busy   = (state != IDLE);

    // An all-zero or all-one word means the EEPROM read back garbage.
    generate
        for (genvar gi = 0; gi < CALIB_WORDS; gi++) begin : g_word_chk
            assign word_bad[gi] = (calib_mem[gi] == 16'h0000) || (calib_mem[gi] == 16'hFFFF);
        end
    endgenerate
    assign calib_ok = ~|word_bad;

    assign calib_word = (int'(calib_sel) < CALIB_WORDS) ? calib_mem[calib_sel] : 16'h0000;

`ifndef BMP180_ID_CHECK_EN
    logic unused_chip_id;
    assign unused_chip_id = ^CHIP_ID;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            received_q  <= 1'b0;
            kind_reg    <= 2'd0;
            oss_reg     <= 2'd0;
            cnt         <= '0;
            expected    <= '0;
            chip_id     <= 8'h00;
            ut          <= 16'h0000;
            up          <= 19'h00000;
            id_valid    <= 1'b0;
            calib_valid <= 1'b0;
            ut_valid    <= 1'b0;
            up_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                stage[i] <= 8'h00;
            end
            for (int i = 0; i < CALIB_WORDS; i++) begin
                calib_mem[i] <= 16'h0000;
            end
        end else begin
            received_q <= received;
            frame_done <= 1'b0;

            // Opening a frame; a byte arriving in the same cycle is dropped.
            if (frame_start && state != COMMIT) begin
                state       <= COLLECT;
                kind_reg    <= frame_kind;
                oss_reg     <= oss;
                cnt         <= '0;
                expected    <= frame_len(frame_kind);
                frame_error <= (state == COLLECT);
                case (frame_kind)
                    KIND_ID:    id_valid    <= 1'b0;
                    KIND_CALIB: calib_valid <= 1'b0;
                    KIND_TEMP:  ut_valid    <= 1'b0;
                    default:    up_valid    <= 1'b0;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_evt) begin
                            frame_error <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        if (rx_evt) begin
                            if (kind_reg == KIND_CALIB) begin
                                if (cnt[0]) begin
                                    calib_mem[cnt[CW-1:1]][7:0] <= datareceive;
                                end else begin
                                    calib_mem[cnt[CW-1:1]][15:8] <= datareceive;
                                end
                            end else begin
                                stage[cnt[1:0]] <= datareceive;
                            end
                            cnt <= cnt + CW'(1);
                            if (cnt == expected - CW'(1)) begin
                                state <= COMMIT;
                            end
                        end
                    end
                    COMMIT: begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        case (kind_reg)
                            KIND_ID: begin
                                chip_id <= stage[0];
`ifdef BMP180_ID_CHECK_EN
                                if (stage[0] == CHIP_ID) begin
                                    id_valid <= 1'b1;
                                end else begin
                                    frame_error <= 1'b1;
                                end
`else
                                id_valid <= 1'b1;
`endif
                            end
                            KIND_CALIB: begin
                                if (calib_ok) begin
                                    calib_valid <= 1'b1;
                                end else begin
                                    frame_error <= 1'b1;
                                end
                            end
                            KIND_TEMP: begin
                                ut       <= {stage[0], stage[1]};
                                ut_valid <= 1'b1;
                            end
                            default: begin
                                up       <= 19'({stage[0], stage[1], stage[2]} >> (4'd8 - {2'b00, oss_reg}));
                                up_valid <= 1'b1;
                            end
                        endcase
                        // Traffic during the commit cycle cannot be accepted.
                        if (rx_evt || frame_start) begin
                            frame_error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bmp180_frame_collector.md
Name: bmp180_frame_collector

Overview:
- Sits directly downstream of the I2C master byte-receive interface, beside the BMP180 command sequencer.
- Takes the master's received-byte strobe and data, plus a frame descriptor from the sequencer.
- Assembles the BMP180 read frames (chip ID, 22-byte calibration block, raw UT, raw UP) into word-level registers with validity and error flags.
- Provides clean operands for later compensation arithmetic and for display.

Parameters:
- CALIB_BYTES, 22, byte count of the calibration frame (11 big-endian 16-bit words, AC1..MD).
- CHIP_ID, 8'h55, expected BMP180 ID value; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse from the sequencer; opens a new frame.
- frame_kind  input  2  sampled on frame_start: 0=ID, 1=CALIB, 2=TEMP, 3=PRESS.
- oss  input  2  oversampling setting; sampled on frame_start; used only for PRESS.
- received  input  1  level from I2C master; a byte is taken on its rising edge.
- datareceive  input  8  byte from I2C master; valid while received is high.
- calib_sel  input  4  calibration word index 0..10; 11..15 read as 16'h0000.
- calib_word  output  16  combinational read of the selected calibration word.
- chip_id  output  8  last captured ID byte.
- ut  output  16  raw temperature {MSB,LSB}.
- up  output  19  raw pressure ({MSB,LSB,XLSB} >> (8-oss)), zero-extended.
- id_valid, calib_valid, ut_valid, up_valid  output  1 each  sticky flags; set on frame completion.
- frame_done  output  1  one-cycle pulse on any frame completion.
- busy  output  1  high while a frame is open.
- frame_error  output  1  sticky; see Behaviour.

Behaviour:
- Reset (async, immediate): all outputs 0; calibration store cleared; FSM to IDLE; edge detector history cleared.
- Byte strobe:
  - rx_evt = received & ~received_q, with received_q registered.
  - The byte is datareceive sampled in the rx_evt cycle.
  - Back-to-back bytes need at least one cycle with received low between them.
- FSM states:
  - IDLE:
    - frame_start -> COLLECT.
    - Latch kind and oss; byte counter cnt=0.
    - expected = 1 (ID), CALIB_BYTES, 2 (TEMP), 3 (PRESS).
    - Clear the valid flag of this kind only.
  - COLLECT:
    - Each rx_evt writes the byte into a staging register at position cnt, then cnt++.
    - When the byte with cnt==expected-1 is written -> COMMIT on the next cycle.
  - COMMIT (1 cycle):
    - Copy staging to output registers, set the matching *_valid, pulse frame_done.
    - -> IDLE.
    - Outputs change exactly 1 cycle after the final rx_evt cycle.
  - busy = (state != IDLE).
- CALIB writes:
  - Written directly into the 11x16 store: even cnt -> word[cnt/2][15:8]; odd cnt -> word[cnt/2][7:0].
  - calib_valid is set at COMMIT only if no word equals 16'h0000 or 16'hFFFF.
  - Otherwise calib_valid stays 0 and frame_error is set.
- PRESS arithmetic:
  - Form the 24-bit value {b0,b1,b2}, shift right logically by (8-oss).
  - oss=0 gives 16 significant bits; oss=3 gives 19.
- Boundary conditions:
  - frame_start while in COLLECT: abort the current frame, no commit, set frame_error, restart with the new descriptor in the same cycle.
  - rx_evt in IDLE: byte ignored, set frame_error.
  - frame_start and rx_evt in the same cycle while IDLE: frame opens; that byte is ignored (not counted).
  - rx_evt during COMMIT: ignored, frame_error set.
- frame_error clears only on reset or on a frame_start received in IDLE.
- Previous ut/up/chip_id values are held until a new frame of the same kind commits.

Optional Feature:
- Macro: BMP180_ID_CHECK_EN.
- Defined: an ID frame sets id_valid only if the byte equals CHIP_ID. On mismatch, chip_id is still updated, id_valid stays 0, and frame_error is set.
- Undefined: any ID byte sets id_valid; the CHIP_ID parameter is unused.

Test Plan:
- ID frame, kind=0, byte 8'h55 -> chip_id=8'h55, id_valid=1, frame_done pulses 1 cycle after rx_evt. With BMP180_ID_CHECK_EN and byte 8'h54 -> id_valid=0, frame_error=1.
- CALIB frame of 22 bytes 8'h01..8'h16 -> calib_sel=0 gives 16'h0102, calib_sel=10 gives 16'h1516, calib_valid=1. Repeat with bytes 2,3 = 8'h00 -> calib_valid=0, frame_error=1.
- TEMP frame 8'h6C,8'hFA -> ut=16'h6CFA, ut_valid=1. PRESS oss=0, bytes 8'h5D,8'h23,8'h00 -> up=19'h05D23. oss=3, bytes 8'h5D,8'h23,8'hE0 -> up=19'h2E91F.
- TEMP frame aborted after 1 byte by frame_start(kind=3) -> no ut update, frame_error=1, the following 3 bytes commit up normally.
- Stray rx_evt in IDLE -> frame_error=1, no outputs change. Reset asserted mid-CALIB (byte 9) -> all outputs and valids 0 immediately, busy=0.
- received held high for 5 cycles -> exactly one byte counted.
